histo_readout_seq: RTL and testbench

//  Sequences readout of the trigger-board channel histograms to the host byte link.
//  On a start pulse it steps histostosend over all channels and waits for the registered histogram mux to settle.
//  It captures one 32-bit count per channel and streams it as 4 bytes over a valid/ready byte interface.

---
 rtl/trigboard_pkg.sv | 36 +++
 rtl/histo_readout_seq_if.sv | 35 +++
 rtl/byte_ser32.sv | 62 ++++++
 rtl/histo_readout_seq.sv | 166 ++++++++++++++++
 tb/tb_histo_readout_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trigboard_pkg
//  Purpose  : Shared types and defaults for the trigger-board histogram
//             readout sequencer (state encoding, framing byte, sizes).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package trigboard_pkg;

  localparam int unsigned NCHAN_DEFAULT    = 16;
  localparam int unsigned NROW_DEFAULT     = 8;
  localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'hA5;

  // Readout sequencer states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_SELECT  = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_SEND    = 3'd5,
    S_CLEAR   = 3'd6,
    S_FIN     = 3'd7
  } hseq_state_t;

  // Out-of-range row requests fall back to row 0 instead of reading
  // undefined bits of the flattened histogram bus.
  function automatic logic [2:0] clamp_row(input logic [2:0] row,
                                           input int unsigned nrow);
    if ({29'd0, row} < nrow) return row;
    return 3'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/histo_readout_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : histo_readout_seq_if
//  Purpose  : Bundles the core-side histogram link and the host byte link
//             of the readout sequencer.
//  Signals  : tx_data/tx_valid/tx_ready  byte stream towards serial TX
//             histostosend               channel select towards core
//             resethist                  histogram clear towards core
//             histosout                  flattened rows, row r at [32r+31:32r]
//  Modports : master = sequencer side, slave = core/TX side
//  Revision : 1.0  initial release
// ============================================================================
interface histo_readout_seq_if
  import trigboard_pkg::*;
#(
  parameter int unsigned NROW = NROW_DEFAULT
);
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        histostosend;
  logic              resethist;
  logic [NROW*32-1:0] histosout;

  modport master (
    output tx_data, tx_valid, histostosend, resethist,
    input  tx_ready, histosout
  );

  modport slave (
    input  tx_data, tx_valid, histostosend, resethist,
    output tx_ready, histosout
  );
endinterface
`default_nettype wire

// File: rtl/byte_ser32.sv
`default_nettype none
// ============================================================================
//  Module   : byte_ser32
//  Purpose  : Takes a 32-bit word on a load pulse and emits it as four bytes,
//             least significant first, over a valid/ready byte interface.
//  Ports    : clk_adc   in   clock
//             reset     in   synchronous active-high reset
//             load      in   capture word and start emitting
//             word      in   32-bit word to serialize
//             tx_data   out  current byte
//             tx_valid  out  byte valid
//             tx_ready  in   downstream accepts byte
//             last      out  handshake of the fourth byte this cycle
//  Revision : 1.0  initial release
// ============================================================================
module byte_ser32 (
  input  logic        clk_adc,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_active;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_word   <= 32'd0;
      r_idx    <= 2'd0;
      r_active <= 1'b0;
    end else if (load) begin
      r_word   <= word;
      r_idx    <= 2'd0;
      r_active <= 1'b1;
    end else if (r_active && tx_ready) begin
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) r_active <= 1'b0;
    end
  end

  // The held word only changes on load, so the byte stays stable under stall.
  always_comb begin
    tx_data = 8'd0;
    case (r_idx)
      2'd0: tx_data = r_word[7:0];
      2'd1: tx_data = r_word[15:8];
      2'd2: tx_data = r_word[23:16];
      2'd3: tx_data = r_word[31:24];
      default: tx_data = 8'd0;
    endcase
  end

  assign tx_valid = r_active;
  assign last     = r_active && tx_ready && (r_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/histo_readout_seq.sv
`default_nettype none
// ============================================================================
//  Module   : histo_readout_seq
//  Purpose  : Sweeps the channel select over all histogram channels, waits
//             for the core mux to settle, captures one 32-bit count per
//             channel and streams header + counts as bytes to the host link.
//             Optionally pulses resethist after the last channel.
//  Ports    : clk_adc      in   sole clock
//             reset        in   synchronous active-high reset
//             start        in   1-cycle sweep request (ignored while busy)
//             row_sel      in   histogram row, latched at start
//             clear_after  in   latched at start, clear histograms after sweep
//             busy         out  sweep in progress
//             done         out  1-cycle completion pulse
//             bus          --   master side of histo_readout_seq_if
//  Revision : 1.0  initial release
// ============================================================================
module histo_readout_seq
  import trigboard_pkg::*;
#(
  parameter int unsigned NCHAN      = NCHAN_DEFAULT,
  parameter int unsigned NROW       = NROW_DEFAULT,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned CLEAR_CYC  = 4,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEFAULT
)(
  input  logic                clk_adc,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          row_sel,
  input  logic                clear_after,
  output logic                busy,
  output logic                done,
  histo_readout_seq_if.master bus
);

  localparam logic [7:0] c_last_ch = 8'(NCHAN - 1);

  hseq_state_t r_state, w_state_n;
  logic [7:0]  r_ch,    w_ch_n;
  logic [7:0]  r_cnt,   w_cnt_n;
  logic [2:0]  r_row,   w_row_n;
  logic        r_clear, w_clear_n;
  logic [7:0]  r_sel,   w_sel_n;
  logic        w_load;
  logic [31:0] w_word;

  logic [7:0]  w_ser_data;
  logic        w_ser_valid;
  logic        w_ser_last;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ch    <= 8'd0;
      r_cnt   <= 8'd0;
      r_row   <= 3'd0;
      r_clear <= 1'b0;
      r_sel   <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_ch    <= w_ch_n;
      r_cnt   <= w_cnt_n;
      r_row   <= w_row_n;
      r_clear <= w_clear_n;
      r_sel   <= w_sel_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ch_n    = r_ch;
    w_cnt_n   = r_cnt;
    w_row_n   = r_row;
    w_clear_n = r_clear;
    w_sel_n   = r_sel;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_row_n   = clamp_row(row_sel, NROW);
          w_clear_n = clear_after;
          w_ch_n    = 8'd0;
          w_state_n = S_HDR;
        end
      end
      S_HDR: begin
        if (bus.tx_ready) w_state_n = S_SELECT;
      end
      S_SELECT: begin
        w_sel_n   = r_ch;
        w_cnt_n   = 8'(SETTLE_CYC);
        w_state_n = S_SETTLE;
      end
      // Counting SETTLE_CYC down to 0 spends SETTLE_CYC+1 cycles here, so
      // the capture edge is SETTLE_CYC+2 edges after the select update.
      S_SETTLE: begin
        if (r_cnt == 8'd0) w_state_n = S_CAPTURE;
        else               w_cnt_n   = r_cnt - 8'd1;
      end
      S_CAPTURE: begin
        w_load    = 1'b1;
        w_state_n = S_SEND;
      end
      S_SEND: begin
        if (w_ser_last) begin
          if (r_ch == c_last_ch) begin
            if (r_clear) begin
              w_cnt_n   = 8'(CLEAR_CYC - 1);
              w_state_n = S_CLEAR;
            end else begin
              w_state_n = S_FIN;
            end
          end else begin
            w_ch_n    = r_ch + 8'd1;
            w_state_n = S_SELECT;
          end
        end
      end
      S_CLEAR: begin
        if (r_cnt == 8'd0) w_state_n = S_FIN;
        else               w_cnt_n   = r_cnt - 8'd1;
      end
      S_FIN: begin
        w_sel_n   = 8'd0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Row mux over the flattened histogram bus.
  always_comb begin
    w_word = 32'd0;
    for (int r = 0; r < int'(NROW); r++) begin
      if (r_row == 3'(r)) w_word = bus.histosout[r*32 +: 32];
    end
  end

  byte_ser32 u_ser (
    .clk_adc  (clk_adc),
    .reset    (reset),
    .load     (w_load),
    .word     (w_word),
    .tx_data  (w_ser_data),
    .tx_valid (w_ser_valid),
    .tx_ready (bus.tx_ready),
    .last     (w_ser_last)
  );

  // The header byte is driven directly; data bytes come from the serializer,
  // which is idle outside SEND. Data is forced to 0 whenever not valid.
  always_comb begin
    bus.tx_valid = (r_state == S_HDR) || w_ser_valid;
    bus.tx_data  = 8'd0;
    if (r_state == S_HDR)  bus.tx_data = HDR_BYTE;
    else if (w_ser_valid)  bus.tx_data = w_ser_data;
  end

  assign bus.histostosend = r_sel;
  assign bus.resethist    = (r_state == S_CLEAR);
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_histo_readout_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histo_readout_seq
//  Purpose  : Scoreboard bench for histo_readout_seq with a 2-cycle-latency
//             histogram core model and a configurable tx_ready source.
//  Revision : 1.0  initial release
// ============================================================================
module tb_histo_readout_seq;

  logic       clk_adc = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [2:0] row_sel = 3'd0;
  logic       clear_after = 1'b0;
  logic       busy, done;

  histo_readout_seq_if #(.NROW(8)) bus ();

  histo_readout_seq dut (
    .clk_adc     (clk_adc),
    .reset       (reset),
    .start       (start),
    .row_sel     (row_sel),
    .clear_after (clear_after),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk_adc = ~clk_adc;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  q[$];
  logic [31:0] histos [8][16];
  logic [3:0]  sel_d1 = 4'd0;

  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int sw_bytes, sw_done, sw_rh, sw_rh_at_done, sw_bytes_at_rh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: histostosend registered, then row mux registered (latency 2).
  initial begin
    bus.histosout = '0;
    forever begin
      @(posedge clk_adc);
      sel_d1 <= bus.histostosend[3:0];
      for (int r = 0; r < 8; r++) bus.histosout[r*32 +: 32] <= histos[r][sel_d1];
      if (bus.resethist)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 16; c++) histos[r][c] = 32'd0;
    end
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk_adc);
      #1;
      case (rdy_mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every accepted byte with the scoreboard, checks hold
  // under stall, and tracks done/resethist per sweep.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk_adc);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_vec++;
          if (!(bus.tx_valid && bus.tx_data == prev_data)) begin
            n_err++;
            $display("FAIL tx_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                     bus.tx_valid, bus.tx_data, prev_data);
          end
        end
        if (bus.tx_valid && bus.tx_ready) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL byte_unexpected: got %0h expected none", bus.tx_data);
          end else begin
            exp = q.pop_front();
            if (bus.tx_data !== exp) begin
              n_err++;
              $display("FAIL byte[%0d]: got %0h expected %0h", sw_bytes, bus.tx_data, exp);
            end
          end
          sw_bytes++;
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (bus.resethist) begin
          if (sw_rh == 0) sw_bytes_at_rh = sw_bytes;
          sw_rh++;
        end
        if (done) begin
          sw_done++;
          sw_rh_at_done = sw_rh;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic init_histos();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        if (r == 0) histos[r][c] = 32'(c) * 32'h01010101;
        else        histos[r][c] = 32'(r) * 32'h10000000 + 32'(c) * 32'h00000111 + 32'h00A00000;
    histos[7][5] = 32'hDEADBEEF;
  endtask

  task automatic push_sweep(input int row);
    logic [31:0] w;
    q.push_back(8'hA5);
    for (int c = 0; c < 16; c++) begin
      w = histos[row][c];
      for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic clear_sw();
    sw_bytes = 0; sw_done = 0; sw_rh = 0; sw_rh_at_done = 0; sw_bytes_at_rh = 0;
  endtask

  task automatic pulse_start(input logic [2:0] row, input logic clr);
    @(posedge clk_adc); #1;
    start = 1'b1; row_sel = row; clear_after = clr;
    @(posedge clk_adc); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (sw_done == 0 && k < budget) begin
      @(posedge clk_adc); #2;
      k++;
    end
    n_vec++;
    if (sw_done == 0) begin
      n_err++;
      $display("FAIL %s_done: got none expected pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset(input string name, input int done_exp);
    @(posedge clk_adc); #1;
    reset = 1'b1;
    @(posedge clk_adc);
    @(negedge clk_adc);
    check({name, "_tx_valid"},     32'(bus.tx_valid),     32'd0);
    check({name, "_tx_data"},      32'(bus.tx_data),      32'd0);
    check({name, "_resethist"},    32'(bus.resethist),    32'd0);
    check({name, "_busy"},         32'(busy),             32'd0);
    check({name, "_done"},         32'(done),             32'd0);
    check({name, "_histostosend"}, 32'(bus.histostosend), 32'd0);
    check({name, "_no_done"},      32'(sw_done),          32'(done_exp));
    #1 reset = 1'b0;
  endtask

  task automatic run_sweep(input logic [2:0] row, input logic clr, input logic poke,
                           input string name);
    push_sweep(int'(row));
    clear_sw();
    pulse_start(row, clr);
    if (poke) begin
      for (int k = 0; k < 2000 && sw_bytes < 10; k++) begin @(posedge clk_adc); #2; end
      pulse_start(3'd0, 1'b1);   // must be ignored, including its row/clear
      row_sel = row;
    end
    wait_done(3000, name);
    repeat (6) @(posedge clk_adc);
    #2;
    check({name, "_done_count"},   32'(sw_done),          32'd1);
    check({name, "_byte_count"},   32'(sw_bytes),         32'd65);
    check({name, "_queue_empty"},  32'(q.size()),         32'd0);
    check({name, "_busy_after"},   32'(busy),             32'd0);
    check({name, "_sel_after"},    32'(bus.histostosend), 32'd0);
    check({name, "_rh_cycles"},    32'(sw_rh),            clr ? 32'd4 : 32'd0);
    if (clr) begin
      check({name, "_rh_before_done"}, 32'(sw_rh_at_done),  32'd4);
      check({name, "_rh_after_byte"},  32'(sw_bytes_at_rh), 32'd65);
    end
  endtask

  initial begin
    init_histos();
    clear_sw();
    repeat (2) @(posedge clk_adc);
    do_reset("reset", 0);

    rdy_mode = 0;
    run_sweep(3'd0, 1'b0, 1'b0, "basic_row0");

    rdy_mode = 1;
    run_sweep(3'd0, 1'b0, 1'b0, "random_ready");

    rdy_mode = 0;
    run_sweep(3'd7, 1'b0, 1'b1, "busy_start_row7");
    repeat (100) @(posedge clk_adc);
    #2;
    check("busy_start_no_resweep_done", 32'(sw_done),  32'd1);
    check("busy_start_no_resweep_busy", 32'(busy),     32'd0);
    check("busy_start_no_resweep_bytes", 32'(sw_bytes), 32'd65);

    rdy_mode = 1;
    run_sweep(3'd3, 1'b1, 1'b0, "clear_sweep");
    rdy_mode = 0;
    run_sweep(3'd3, 1'b0, 1'b0, "after_clear_zero");

    // Reset while stalled in SEND.
    init_histos();
    push_sweep(1);
    clear_sw();
    pulse_start(3'd1, 1'b0);
    for (int k = 0; k < 2000 && sw_bytes < 3; k++) begin @(posedge clk_adc); #2; end
    rdy_mode = 2;
    repeat (10) @(posedge clk_adc);
    #2;
    check("send_stall_valid", 32'(bus.tx_valid), 32'd1);
    do_reset("reset_in_send", 0);
    q.delete();
    rdy_mode = 0;
    run_sweep(3'd1, 1'b0, 1'b0, "fresh_after_send_reset");

    // Reset while resethist is asserted.
    push_sweep(2);
    clear_sw();
    pulse_start(3'd2, 1'b1);
    for (int k = 0; k < 3000 && !bus.resethist; k++) begin @(posedge clk_adc); #2; end
    check("clear_reached", 32'(bus.resethist), 32'd1);
    do_reset("reset_in_clear", 0);
    check("clear_abort_queue", 32'(q.size()), 32'd0);
    repeat (10) @(posedge clk_adc);
    #2;
    check("clear_abort_no_done", 32'(sw_done),       32'd0);
    check("clear_abort_rh_low",  32'(bus.resethist), 32'd0);
    init_histos();
    run_sweep(3'd0, 1'b0, 1'b0, "fresh_after_clear_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
